span_ims_sched: RTL

Job scheduler for the SPAN inter-month spread charge engine. It arbitrates between NREQ portfolio requesters and loads the granted requester's legs and a snapshot of the product configuration into registers that drive the engine. It pulses the engine's synchronous active-low reset, holds inputs stable for SETTLE cycles, then captures TSC and returns it tagged with the requester id. One job is in flight at a time; the engine itself is free-running and has no handshake of its own.

---
 rtl/span_ims_sched.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/span_ims_sched.sv
// span_ims_sched -- job scheduler for the SPAN inter-month spread charge engine.
//
// Round-robin arbitrates NREQ requesters, loads the winner's legs and a snapshot
// of the staged product configuration into the engine input registers, pulses
// the engine reset for one cycle, waits SETTLE cycles, then captures eng_tsc and
// returns it tagged with the requester index. One job in flight at a time.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   req / gnt           level requests; one-hot grant held for the whole LOAD phase
//   in_valid/in_ready   leg beat handshake (in_ready only in LOAD)
//   in_pos/in_mat/in_last  leg position, maturity index, final-leg flag
//   cfg_we/addr/data    config staging writes (always accepted)
//   eng_rst_n           engine synchronous active-low reset
//   eng_pos/eng_mat     per-slot leg inputs to the engine
//   eng_tier/sc/out     active config snapshot driven to the engine
//   eng_tsc             engine total spread charge
//   res_valid/ready     result handshake
//   res_tsc/res_id      captured TSC and owning requester index
module span_ims_sched #(
    parameter int NREQ   = 2,
    parameter int LEGS   = 8,
    parameter int SETTLE = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    output logic [NREQ-1:0]           gnt,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [15:0]               in_pos,
    input  logic [7:0]                in_mat,
    input  logic                      in_last,
    input  logic                      cfg_we,
    input  logic [3:0]                cfg_addr,
    input  logic [7:0]                cfg_data,
    output logic                      eng_rst_n,
    output logic [LEGS-1:0][15:0]     eng_pos,
    output logic [LEGS-1:0][7:0]      eng_mat,
    output logic [2:0][3:0]           eng_tier,
    output logic [5:0][7:0]           eng_sc,
    output logic [2:0][7:0]           eng_out,
    input  logic [15:0]               eng_tsc,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [15:0]               res_tsc,
    output logic [$clog2(NREQ)-1:0]   res_id
);

    localparam int IDW = $clog2(NREQ);
    localparam int KW  = (LEGS > 1) ? $clog2(LEGS) : 1;
    localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_SETTLE,
        S_RESULT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  win_idx;
    logic [KW-1:0]   slot;
    logic [CW-1:0]   cnt;
    logic            load_end;

    logic [2:0][3:0] stg_tier, tier_nx;
    logic [5:0][7:0] stg_sc,   sc_nx;
    logic [2:0][7:0] stg_out,  out_nx;

    // Round robin: lowest requesting index above rr_ptr, else lowest at or
    // below it. Both loops run high-to-low so the lowest match is written last,
    // and the second loop overrides the wrap-around candidate when one exists.
    always_comb begin
        win_idx = '0;
        for (int unsigned j = NREQ; j > 0; j--) begin
            if (req[j-1] && ((j - 1) <= 32'(rr_ptr))) win_idx = IDW'(j - 1);
        end
        for (int unsigned j = NREQ; j > 0; j--) begin
            if (req[j-1] && ((j - 1) > 32'(rr_ptr))) win_idx = IDW'(j - 1);
        end
    end

    // Staging with the current write applied; the grant snapshot reads this so
    // a write in the grant cycle reaches that job.
    always_comb begin
        tier_nx = stg_tier;
        sc_nx   = stg_sc;
        out_nx  = stg_out;
        if (cfg_we) begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (cfg_addr == 4'(i)) tier_nx[i] = cfg_data[3:0];
            end
            for (int unsigned i = 0; i < 6; i++) begin
                if (cfg_addr == 4'(i + 3)) sc_nx[i] = cfg_data;
            end
            for (int unsigned i = 0; i < 3; i++) begin
                if (cfg_addr == 4'(i + 9)) out_nx[i] = cfg_data;
            end
        end
    end

    // LEGS-th beat ends the phase even without in_last.
    assign load_end = in_valid && (in_last || (slot == KW'(LEGS - 1)));

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        gnt       = '0;
        case (state)
            S_IDLE:   if (|req) state_nx = S_LOAD;
            S_LOAD: begin
                in_ready     = 1'b1;
                gnt[gnt_idx] = 1'b1;
                if (load_end) state_nx = S_CLEAR;
            end
            S_CLEAR:  state_nx = S_SETTLE;
            S_SETTLE: if (cnt == CW'(SETTLE - 1)) state_nx = S_RESULT;
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nx = S_IDLE;
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    assign res_id = gnt_idx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr    <= IDW'(NREQ - 1);
            gnt_idx   <= '0;
            slot      <= '0;
            cnt       <= '0;
            eng_rst_n <= 1'b0;
            eng_pos   <= '0;
            eng_mat   <= '0;
            eng_tier  <= '0;
            eng_sc    <= '0;
            eng_out   <= '0;
            res_tsc   <= '0;
            stg_tier  <= '0;
            stg_sc    <= '0;
            stg_out   <= '0;
        end else begin
            eng_rst_n <= (state_nx != S_CLEAR);
            stg_tier  <= tier_nx;
            stg_sc    <= sc_nx;
            stg_out   <= out_nx;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        gnt_idx  <= win_idx;
                        slot     <= '0;
                        eng_tier <= tier_nx;
                        eng_sc   <= sc_nx;
                        eng_out  <= out_nx;
                        // Empty slots: maturity 8'hFF matches no tier.
                        eng_pos  <= '0;
                        eng_mat  <= '1;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        eng_pos[slot] <= in_pos;
                        eng_mat[slot] <= in_mat;
                        slot          <= slot + KW'(1);
                    end
                end
                S_CLEAR:  cnt <= '0;
                S_SETTLE: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(SETTLE - 1)) res_tsc <= eng_tsc;
                end
                S_RESULT: begin
                    if (res_ready) rr_ptr <= gnt_idx;
                end
                default: ;
            endcase
        end
    end

endmodule
